// File: rtl/sphere_pkg.sv
// Shared FSM state type and metric constants for the sphere-decoder search blocks.
package sphere_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // All-ones metric of width w; the "nothing seen yet" value for running minima.
    function automatic longint unsigned metric_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Magnitude substituted for the most-negative operand so |x| fits in w-1 bits.
    function automatic longint unsigned clamp_mag(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/l1_metric.sv
// Combinational |re|+|im| with the most-negative operand clamped; never wraps.
module l1_metric
    import sphere_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] re,
    input  logic [WIDTH-1:0] im,
    output logic [WIDTH-1:0] metric
);

    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-2:0] CLAMP_MAG = (WIDTH-1)'(clamp_mag(WIDTH));

    logic [WIDTH-2:0] mag_re;
    logic [WIDTH-2:0] mag_im;

    // For any negative value other than MOST_NEG, |x| < 2^(WIDTH-1), so the low bits suffice.
    always_comb begin
        mag_re = re[WIDTH-2:0];
        if (re == MOST_NEG)
            mag_re = CLAMP_MAG;
        else if (re[WIDTH-1])
            mag_re = -re[WIDTH-2:0];

        mag_im = im[WIDTH-2:0];
        if (im == MOST_NEG)
            mag_im = CLAMP_MAG;
        else if (im[WIDTH-1])
            mag_im = -im[WIDTH-2:0];

        metric = {1'b0, mag_re} + {1'b0, mag_im};
    end

endmodule

// File: rtl/l1_min_search.sv
// Streams a burst of candidates through one shared L1 metric unit and reports the minimum.
// Optional runner-up metric output enabled by defining L1_MIN_RUNNER_UP_EN.
//
// state  | meaning
// IDLE   | waiting for start; last result held on out_idx/out_metric
// LOAD   | accepting candidates, in_ready high
// DRAIN  | one cycle for the final compare to land
// REPORT | result presented until out_ready
module l1_min_search
    import sphere_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int NUM_CAND = 8,
    parameter int IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_metric,
`ifdef L1_MIN_RUNNER_UP_EN
    output logic [WIDTH-1:0] out_metric2,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] METRIC_MAX = WIDTH'(metric_max(WIDTH));
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CAND - 1);

    state_t           state, state_nxt;
    logic             hs;
    logic [IDX_W-1:0] cnt;
    logic [WIDTH-1:0] metric;
    logic             stage_valid;
    logic [WIDTH-1:0] stage_metric;
    logic [IDX_W-1:0] stage_idx;
    logic [WIDTH-1:0] best_metric, best_metric_nxt;
    logic [IDX_W-1:0] best_idx, best_idx_nxt;

    l1_metric #(.WIDTH(WIDTH)) u_metric (
        .re     (in_real),
        .im     (in_imag),
        .metric (metric)
    );

    assign hs = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN:  state_nxt = REPORT;
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict compare: a later candidate with an equal metric never displaces the earlier one.
    always_comb begin
        best_metric_nxt = best_metric;
        best_idx_nxt    = best_idx;
        if (stage_valid && stage_metric < best_metric) begin
            best_metric_nxt = stage_metric;
            best_idx_nxt    = stage_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            stage_valid  <= 1'b0;
            stage_metric <= '0;
            stage_idx    <= '0;
            best_metric  <= METRIC_MAX;
            best_idx     <= '0;
            out_idx      <= '0;
            out_metric   <= '0;
        end else begin
            stage_valid <= hs;
            if (hs) begin
                stage_metric <= metric;
                stage_idx    <= cnt;
                cnt          <= cnt + 1'b1;
            end
            if (state == IDLE && start) begin
                cnt         <= '0;
                best_metric <= METRIC_MAX;
                best_idx    <= '0;
            end else begin
                best_metric <= best_metric_nxt;
                best_idx    <= best_idx_nxt;
            end
            // The last compare lands on this same edge, so capture its combinational result.
            if (state == DRAIN) begin
                out_idx    <= best_idx_nxt;
                out_metric <= best_metric_nxt;
            end
        end
    end

`ifdef L1_MIN_RUNNER_UP_EN
    logic [WIDTH-1:0] second_metric, second_metric_nxt;

    always_comb begin
        second_metric_nxt = second_metric;
        if (stage_valid) begin
            if (stage_metric < best_metric)
                second_metric_nxt = best_metric;
            else if (stage_metric < second_metric)
                second_metric_nxt = stage_metric;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_metric <= METRIC_MAX;
            out_metric2   <= METRIC_MAX;
        end else begin
            if (state == IDLE && start)
                second_metric <= METRIC_MAX;
            else
                second_metric <= second_metric_nxt;
            if (state == DRAIN)
                out_metric2 <= second_metric_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_l1_min_search.sv
// Self-checking bench for l1_min_search: table bursts, random bursts against a reference model,
// latency, backpressure and mid-burst reset sequences.
module tb_l1_min_search;

    localparam int W  = 20;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [N-1:0][W-1:0] re;
        logic [N-1:0][W-1:0] im;
    } vec_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  metric;
        logic [W-1:0]  metric2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_real;
    logic [W-1:0]  in_imag;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [W-1:0]  out_metric;
`ifdef L1_MIN_RUNNER_UP_EN
    logic [W-1:0]  out_metric2;
`endif
    logic          busy;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    l1_min_search #(.WIDTH(W), .NUM_CAND(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_metric (out_metric),
`ifdef L1_MIN_RUNNER_UP_EN
        .out_metric2(out_metric2),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Stimulus table: candidate parts and hand-derived results.
    int t_re [5][N] = '{
        '{6, -7, 5, -2, 0, 1, -10, 3},
        '{524287, -524288, -524288, 524287, -524287, 500000, -524288, 524287},
        '{100, 100, 100, 100, 100, 100, 100, 0},
        '{-1, 2, 2, 2, 0, 2, 2, 2},
        '{50, 50, 50, 50, 50, 50, 50, 50}
    };
    int t_im [5][N] = '{
        '{-4, 0, 7, 1, -9, 2, -10, -2},
        '{524287, -524288, 524000, -524288, -524287, -524288, -524287, -524286},
        '{100, 100, 100, 100, 100, 100, 100, 0},
        '{0, -2, -2, -2, -1, -2, -2, -2},
        '{-50, -50, -50, -50, -50, -50, -50, -50}
    };
    int t_idx [5] = '{3, 5, 7, 0, 0};
    int t_met [5] = '{3, 1024287, 0, 1, 100};
    int t_m2  [5] = '{3, 1048287, 200, 1, 100};

    vec_t vecs [5];
    exp_t exps [5];

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int absc(input logic [W-1:0] x);
        int s;
        s = int'($signed(x));
        if (s == -(1 << (W - 1))) return (1 << (W - 1)) - 1;
        return (s < 0) ? -s : s;
    endfunction

    function automatic exp_t model(input vec_t v);
        int   m [N];
        int   bi;
        int   sec;
        exp_t e;
        bi  = 0;
        sec = (1 << W) - 1;
        for (int i = 0; i < N; i++) m[i] = absc(v.re[i]) + absc(v.im[i]);
        for (int i = 1; i < N; i++) if (m[i] < m[bi]) bi = i;
        for (int i = 0; i < N; i++) if (i != bi && m[i] < sec) sec = m[i];
        e.idx     = IW'(bi);
        e.metric  = W'(m[bi]);
        e.metric2 = W'(sec);
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   in_ready,   0);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_idx"},    out_idx,    0);
        chk({tag, "_out_metric"}, out_metric, 0);
        chk({tag, "_busy"},       busy,       0);
    endtask

    // Returns at the negedge after the last accepted candidate (the DRAIN cycle for a full burst).
    task automatic drive_burst(input vec_t v, input bit bubbles, input bit poke_start, input int count);
        int i;
        int guard;
        bit took;
        i     = 0;
        guard = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = poke_start;
        chk("load_busy", busy, 1);
        chk("load_in_ready", in_ready, 1);
        while (i < count && guard < 400) begin
            guard++;
            in_valid = !(bubbles && $urandom_range(0, 2) == 0);
            in_real  = v.re[i];
            in_imag  = v.im[i];
            took     = in_valid && in_ready;
            @(negedge clk);
            if (took) i++;
        end
        chk("burst_accepted", i, count);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_result(input int hold, input bit accept_start);
        int   guard;
        exp_t e;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("scoreboard_nonempty", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("out_idx", out_idx, e.idx);
        chk("out_metric", out_metric, e.metric);
`ifdef L1_MIN_RUNNER_UP_EN
        chk("out_metric2", out_metric2, e.metric2);
`endif
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_idx", out_idx, e.idx);
            chk("hold_out_metric", out_metric, e.metric);
        end
        out_ready = 1'b1;
        start     = accept_start;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("accept_busy_clear", busy, 0);
        chk("accept_out_valid_clear", out_valid, 0);
        chk("idle_out_idx_held", out_idx, e.idx);
        chk("idle_out_metric_held", out_metric, e.metric);
    endtask

    initial begin
        vec_t rv;

        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) begin
                vecs[v].re[i] = W'(t_re[v][i]);
                vecs[v].im[i] = W'(t_im[v][i]);
            end
            exps[v].idx     = IW'(t_idx[v]);
            exps[v].metric  = W'(t_met[v]);
            exps[v].metric2 = W'(t_m2[v]);
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Table bursts; odd entries see input bubbles, entry 1 is held 5 cycles under backpressure.
        for (int v = 0; v < 4; v++) begin
            sb.push_back(exps[v]);
            drive_burst(vecs[v], (v % 2) == 1, 1'b0, N);
            wait_result((v == 1) ? 5 : 0, v == 2);
        end

        // Random bursts against the reference model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r == 0) begin
                    rv.re[i] = W'(int'($urandom_range(0, 8)) - 4);
                    rv.im[i] = W'(int'($urandom_range(0, 8)) - 4);
                end else begin
                    rv.re[i] = W'(int'($urandom_range(0, 1048575)) - 524288);
                    rv.im[i] = W'(int'($urandom_range(0, 1048575)) - 524288);
                end
            end
            if (r == 2) rv.re[3] = W'(-524288);
            sb.push_back(model(rv));
            drive_burst(rv, 1'b1, 1'b0, N);
            wait_result(r, 1'b0);
        end

        // Latency with continuous valid and start held through LOAD; in_valid left high in DRAIN.
        sb.push_back(exps[1]);
        drive_burst(vecs[1], 1'b0, 1'b1, N);
        in_valid = 1'b1;
        chk("drain_in_ready", in_ready, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_busy", busy, 1);
        @(negedge clk);
        chk("report_out_valid", out_valid, 1);
        chk("report_in_ready", in_ready, 0);
        in_valid = 1'b0;
        wait_result(2, 1'b1);

        // Reset after 4 candidates; outputs must clear before the next clock edge.
        drive_burst(vecs[0], 1'b0, 1'b0, 4);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(exps[4]);
        drive_burst(vecs[4], 1'b0, 1'b0, N);
        wait_result(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
